// File: rtl/demosaic_pkg.sv
// Shared definitions for the demosaic schedulers: CFA phase codes, sequencer
// states and the R/B phase test.
package demosaic_pkg;

    localparam logic [1:0] PAT_RGGB = 2'd0;
    localparam logic [1:0] PAT_GRBG = 2'd1;
    localparam logic [1:0] PAT_GBRG = 2'd2;
    localparam logic [1:0] PAT_BGGR = 2'd3;

    localparam int unsigned DW_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_FLUSH
    } state_e;

    // True when the site at (x,y) carries R or B for the given CFA phase.
    function automatic logic is_rb(input logic x0, input logic y0, input logic [1:0] pat);
        return (x0 ^ y0 ^ pat[0] ^ pat[1]) == 1'b0;
    endfunction

endpackage

// File: rtl/demosaic_line_ring.sv
// Four-line ring buffer: one write port, four parallel read lanes (one per slot),
// synchronous read-before-write.
module demosaic_line_ring #(
    parameter int unsigned IMG_W = 1920,
    parameter int unsigned DW    = 10,
    parameter int unsigned XW    = 11
) (
    input  logic            clk,
    input  logic            we,
    input  logic [1:0]      wslot,
    input  logic [XW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic            re,
    input  logic [XW-1:0]   raddr,
    output logic [4*DW-1:0] rdata
);

    for (genvar s = 0; s < 4; s++) begin : g_slot
        logic [DW-1:0] mem [IMG_W];
        logic [DW-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (we && (wslot == 2'(s))) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rd_q <= mem[raddr];
            end
        end

        assign rdata[s*DW +: DW] = rd_q;
    end

endmodule

// File: rtl/demosaic_g_sched.sv
// Column sequencer ahead of the green interpolation kernel. Row border handling is
// edge replication by default, mirroring when DEMOSAIC_BORDER_MIRROR_EN is defined.
module demosaic_g_sched
    import demosaic_pkg::*;
#(
    parameter int unsigned IMG_W     = 1920,
    parameter int unsigned IMG_H     = 1080,
    parameter int unsigned DW        = DW_DEF,
    parameter logic [1:0]  BAYER_PAT = PAT_RGGB
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    input  logic            s_sof,
    input  logic            s_eol,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [5*DW-1:0] m_col,
    output logic            m_is_rb,
    output logic            m_first,
    output logic            m_last,
    output logic            m_sof,
    output logic            err_len
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_CTR0 = YW'(IMG_H - 2);

    function automatic int map_row(input int r);
`ifdef DEMOSAIC_BORDER_MIRROR_EN
        if (r < 0) return -r;
        if (r > int'(IMG_H) - 1) return 2 * (int'(IMG_H) - 1) - r;
        return r;
`else
        if (r < 0) return 0;
        if (r > int'(IMG_H) - 1) return int'(IMG_H) - 1;
        return r;
`endif
    endfunction

    state_e          state_q, state_d;
    logic [XW-1:0]   in_x_q, in_x_d;
    logic [YW-1:0]   in_y_q, in_y_d;
    logic            fl_row_q, fl_row_d;
    logic            fl_done_q, fl_done_d;
    logic            m_valid_q, m_valid_d;
    logic            err_q, err_d;
    logic            rdy_en_q;
    logic [DW-1:0]   live_q, live_d;
    logic [4:0]      sel_live_q, sel_live_d;
    logic [9:0]      sel_slot_q, sel_slot_d;
    logic            rb_q, rb_d, first_q, first_d, last_q, last_d, sof_q, sof_d;

    logic            accept, start, beat, x_last, y_last, issue, iss_live;
    logic [XW-1:0]   px, iss_x;
    logic [YW-1:0]   py, iss_y;
    logic            rd_en;
    logic [4*DW-1:0] ring_rdata;
    logic [DW-1:0]   lane [4];
    int              r;

    demosaic_line_ring #(
        .IMG_W (IMG_W),
        .DW    (DW),
        .XW    (XW)
    ) u_ring (
        .clk   (clk),
        .we    (beat),
        .wslot (py[1:0]),
        .waddr (px),
        .wdata (s_data),
        .re    (rd_en),
        .raddr (iss_x),
        .rdata (ring_rdata)
    );

    always_comb begin
        state_d    = state_q;
        in_x_d     = in_x_q;
        in_y_d     = in_y_q;
        fl_row_d   = fl_row_q;
        fl_done_d  = fl_done_q;
        m_valid_d  = m_valid_q && !m_ready;
        err_d      = err_q;
        live_d     = live_q;
        sel_live_d = sel_live_q;
        sel_slot_d = sel_slot_q;
        rb_d       = rb_q;
        first_d    = first_q;
        last_d     = last_q;
        sof_d      = sof_q;
        issue      = 1'b0;
        iss_live   = 1'b0;
        iss_y      = '0;
        rd_en      = 1'b0;
        r          = 0;

        unique case (state_q)
            ST_IDLE, ST_FILL: s_ready = rdy_en_q;
            ST_RUN:           s_ready = rdy_en_q && (m_ready || !m_valid_q);
            default:          s_ready = 1'b0;
        endcase

        accept = s_valid && s_ready;
        start  = accept && s_sof;
        // In IDLE only a start-of-frame beat carries a pixel; others are dropped.
        beat   = start || (accept && ((state_q == ST_FILL) || (state_q == ST_RUN)));
        px     = start ? '0 : in_x_q;
        py     = start ? '0 : in_y_q;
        iss_x  = px;
        x_last = (px == X_LAST);
        y_last = (py == Y_LAST);

        if (beat) begin
            err_d  = err_q | (s_eol != x_last);
            in_x_d = x_last ? '0 : px + 1'b1;
            in_y_d = x_last ? (y_last ? '0 : py + 1'b1) : py;
            if (start) begin
                m_valid_d = 1'b0;
            end
            if (py < YW'(2)) begin
                state_d = (x_last && (py == YW'(1))) ? ST_RUN : ST_FILL;
            end else begin
                issue    = 1'b1;
                iss_live = 1'b1;
                iss_y    = py - YW'(2);
                if (x_last && y_last) begin
                    state_d   = ST_FLUSH;
                    fl_row_d  = 1'b0;
                    fl_done_d = 1'b0;
                end
            end
        end else if (state_q == ST_FLUSH) begin
            if (!fl_done_q && (m_ready || !m_valid_q)) begin
                issue  = 1'b1;
                iss_y  = Y_CTR0 + YW'(fl_row_q);
                in_x_d = x_last ? '0 : in_x_q + 1'b1;
                if (x_last) begin
                    fl_row_d  = 1'b1;
                    fl_done_d = fl_row_q;
                end
            end else if (fl_done_q && m_valid_q && m_ready) begin
                state_d = ST_IDLE;
                in_x_d  = '0;
                in_y_d  = '0;
            end
        end

        if (issue) begin
            rd_en     = 1'b1;
            m_valid_d = 1'b1;
            live_d    = s_data;
            rb_d      = is_rb(iss_x[0], iss_y[0], BAYER_PAT);
            first_d   = (iss_x == '0);
            last_d    = (iss_x == X_LAST);
            sof_d     = (iss_x == '0) && (iss_y == '0);
            // Row y+2 in RUN is the live pixel; its ring slot still holds row y-2.
            for (int d = 0; d < 5; d++) begin
                r = map_row(int'(iss_y) - 2 + d);
                sel_slot_d[2*d +: 2] = 2'(r);
                sel_live_d[d]        = iss_live && (r == int'(iss_y) + 2);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane[i] = ring_rdata[i*DW +: DW];
        end
        m_col = '0;
        if (m_valid_q) begin
            for (int d = 0; d < 5; d++) begin
                m_col[d*DW +: DW] = sel_live_q[d] ? live_q : lane[sel_slot_q[2*d +: 2]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_x_q     <= '0;
            in_y_q     <= '0;
            fl_row_q   <= 1'b0;
            fl_done_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
            live_q     <= '0;
            sel_live_q <= '0;
            sel_slot_q <= '0;
            rb_q       <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            sof_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_x_q     <= in_x_d;
            in_y_q     <= in_y_d;
            fl_row_q   <= fl_row_d;
            fl_done_q  <= fl_done_d;
            m_valid_q  <= m_valid_d;
            err_q      <= err_d;
            rdy_en_q   <= 1'b1;
            live_q     <= live_d;
            sel_live_q <= sel_live_d;
            sel_slot_q <= sel_slot_d;
            rb_q       <= rb_d;
            first_q    <= first_d;
            last_q     <= last_d;
            sof_q      <= sof_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_is_rb = rb_q;
    assign m_first = first_q;
    assign m_last  = last_q;
    assign m_sof   = sof_q;
    assign err_len = err_q;

endmodule

// File: tb/tb_demosaic_g_sched.sv
// Directed bench for demosaic_g_sched on an 8x6 ramp frame, with a frame-level
// reference model and literal border/phase pins.
module tb_demosaic_g_sched;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, s_valid, s_sof, s_eol, m_ready;
    logic [DW-1:0]   s_data;
    logic            s_ready0, m_valid0, m_is_rb0, m_first0, m_last0, m_sof0, err0;
    logic [5*DW-1:0] m_col0;
    logic            s_ready1, m_valid1, m_is_rb1, m_first1, m_last1, m_sof1, err1;
    logic [5*DW-1:0] m_col1;

    demosaic_g_sched #(.IMG_W(W), .IMG_H(H), .DW(DW), .BAYER_PAT(2'd0)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .s_sof(s_sof), .s_eol(s_eol), .m_valid(m_valid0), .m_ready(m_ready), .m_col(m_col0),
        .m_is_rb(m_is_rb0), .m_first(m_first0), .m_last(m_last0), .m_sof(m_sof0),
        .err_len(err0)
    );

    demosaic_g_sched #(.IMG_W(W), .IMG_H(H), .DW(DW), .BAYER_PAT(2'd1)) dut_grbg (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .s_sof(s_sof), .s_eol(s_eol), .m_valid(m_valid1), .m_ready(m_ready), .m_col(m_col1),
        .m_is_rb(m_is_rb1), .m_first(m_first1), .m_last(m_last1), .m_sof(m_sof1),
        .err_len(err1)
    );

    typedef struct {
        logic [5*DW-1:0] col;
        logic rb0, rb1, first, last, sof;
        int x, y;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_fail = 0;
    int   cyc = 0, lat_cyc = -1, abort_cyc = -1;
    bit   stall_mode = 1'b0, cap_en = 1'b0;
    logic [5*DW-1:0] cap_col [W*H];
    logic cap_rb0 [W*H];
    logic cap_rb1 [W*H];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int map_row(input int r);
`ifdef DEMOSAIC_BORDER_MIRROR_EN
        if (r < 0) return -r;
        if (r > H - 1) return 2 * (H - 1) - r;
        return r;
`else
        if (r < 0) return 0;
        if (r > H - 1) return H - 1;
        return r;
`endif
    endfunction

    function automatic logic [5*DW-1:0] pack5(input int a, b, c, d, e);
        logic [5*DW-1:0] v;
        v = {DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
        return v;
    endfunction

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    // Expected column stream: raster of centers, rows y-2..y+2 after substitution.
    task automatic push_cols(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.x = k % W;
            e.y = k / W;
            for (int d = 0; d < 5; d++) begin
                e.col[d*DW +: DW] = DW'(16 * map_row(e.y - 2 + d) + e.x);
            end
            e.rb0   = ((e.x ^ e.y) & 1) == 0;
            e.rb1   = ((e.x ^ e.y ^ 1) & 1) == 0;
            e.first = (e.x == 0);
            e.last  = (e.x == W - 1);
            e.sof   = (e.x == 0) && (e.y == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit sof, input bit eol);
        bit rdy;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eol   = eol;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy = s_ready0;
            @(posedge clk);
            #1;
            if (rdy) return;
        end
        check(1'b0, "send_timeout", 64'd0, 64'd1);
        finish_run();
    endtask

    task automatic send_frame(input int nbeats, input bit bad_eol, input bit mark_lat,
                              input bit mark_abort);
        int x, y;
        bit eol;
        for (int k = 0; k < nbeats; k++) begin
            x   = k % W;
            y   = k / W;
            eol = (bad_eol && y == 0) ? (x == 5) : (x == W - 1);
            send_beat(DW'(16 * y + x), k == 0, eol);
            if (mark_lat && x == 0 && y == 2) lat_cyc = cyc;
            if (mark_abort && k == 0) abort_cyc = cyc;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                #1;
                return;
            end
        end
        check(1'b0, "drain_timeout", 64'(exp_q.size()), 64'd0);
        finish_run();
    endtask

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = stall_mode ? ~m_ready : 1'b1;
        end
    end

    // Compare process: every handshake against the model, plus hold/ready/latency rules.
    initial begin
        exp_t e;
        bit stalled_prev;
        logic [5*DW+3:0] prev;
        stalled_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cyc == lat_cyc)
                    check(m_valid0 && m_first0 && m_sof0, "latency_first_col",
                          64'({m_valid0, m_first0, m_sof0}), 64'h7);
                if (cyc == abort_cyc)
                    check(!m_valid0 && !m_valid1, "abort_drop", 64'(m_valid0), 64'd0);
                if (stalled_prev)
                    check(m_valid0 && ({m_is_rb0, m_first0, m_last0, m_sof0, m_col0} == prev),
                          "stall_hold", 64'({m_is_rb0, m_first0, m_last0, m_sof0, m_col0}),
                          64'(prev));
                if (m_valid0 && !m_ready)
                    check(!s_ready0, "stall_ready", 64'(s_ready0), 64'd0);
                if (m_valid0 && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "extra_col", 64'(m_col0), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check({m_is_rb0, m_first0, m_last0, m_sof0, m_col0} ==
                              {e.rb0, e.first, e.last, e.sof, e.col},
                              $sformatf("col_x%0d_y%0d", e.x, e.y),
                              64'({m_is_rb0, m_first0, m_last0, m_sof0, m_col0}),
                              64'({e.rb0, e.first, e.last, e.sof, e.col}));
                        check(m_valid1 && ({m_is_rb1, m_col1} == {e.rb1, e.col}),
                              $sformatf("grbg_col_x%0d_y%0d", e.x, e.y),
                              64'({m_valid1, m_is_rb1, m_col1}), 64'({1'b1, e.rb1, e.col}));
                        if (cap_en) begin
                            cap_col[e.y * W + e.x] = m_col0;
                            cap_rb0[e.y * W + e.x] = m_is_rb0;
                            cap_rb1[e.y * W + e.x] = m_is_rb1;
                        end
                    end
                end
                stalled_prev = m_valid0 && !m_ready;
                prev = {m_is_rb0, m_first0, m_last0, m_sof0, m_col0};
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    initial begin
        logic [5*DW-1:0] want;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        repeat (3) @(negedge clk);
        check(!s_ready0, "reset_s_ready", 64'(s_ready0), 64'd0);
        check(!m_valid0 && m_col0 == '0, "reset_m_valid_col", 64'({m_valid0, m_col0}), 64'd0);
        check({m_is_rb0, m_first0, m_last0, m_sof0, err0} == 5'b0, "reset_tags",
              64'({m_is_rb0, m_first0, m_last0, m_sof0, err0}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check(s_ready0, "ready_after_reset", 64'(s_ready0), 64'd1);

        // A beat without s_sof in IDLE is dropped, then an unstalled ramp frame.
        send_beat(DW'(5), 1'b0, 1'b0);
        cap_en = 1'b1;
        push_cols(W * H);
        send_frame(W * H, 1'b0, 1'b1, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        check(!s_ready0, "flush_ready_low", 64'(s_ready0), 64'd0);
        wait_drain();
        @(negedge clk);
        check(s_ready0 && !m_valid0, "idle_after_flush", 64'({s_ready0, m_valid0}), 64'h2);
        cap_en = 1'b0;

        check(cap_col[2 * W + 3] == pack5(3, 19, 35, 51, 67), "pin_c3_2",
              64'(cap_col[2 * W + 3]), 64'(pack5(3, 19, 35, 51, 67)));
`ifdef DEMOSAIC_BORDER_MIRROR_EN
        want = pack5(32, 16, 0, 16, 32);
`else
        want = pack5(0, 0, 0, 16, 32);
`endif
        check(cap_col[0] == want, "pin_c0_0", 64'(cap_col[0]), 64'(want));
`ifdef DEMOSAIC_BORDER_MIRROR_EN
        want = pack5(48, 64, 80, 64, 48);
`else
        want = pack5(48, 64, 80, 80, 80);
`endif
        check(cap_col[5 * W] == want, "pin_c0_5", 64'(cap_col[5 * W]), 64'(want));
        check(cap_rb0[0] && cap_rb0[W + 1] && !cap_rb0[1], "pin_rb_rggb",
              64'({cap_rb0[0], cap_rb0[W + 1], cap_rb0[1]}), 64'h6);
        check(!cap_rb1[0] && cap_rb1[1], "pin_rb_grbg", 64'({cap_rb1[0], cap_rb1[1]}), 64'h1);

        // Same frame with m_ready toggling every cycle.
        stall_mode = 1'b1;
        push_cols(W * H);
        send_frame(W * H, 1'b0, 1'b0, 1'b0);
        s_valid = 1'b0;
        wait_drain();
        stall_mode = 1'b0;

        // Abort at beat (4,3): 12 columns from the old frame, then a full new frame.
        push_cols(12);
        push_cols(W * H);
        send_frame(3 * W + 4, 1'b0, 1'b0, 1'b0);
        send_frame(W * H, 1'b0, 1'b0, 1'b1);
        s_valid = 1'b0;
        wait_drain();
        @(negedge clk);
        check(!err0, "err_clean", 64'(err0), 64'd0);

        // s_eol at x=5 on row 0 sets err_len; it persists through the next frame.
        push_cols(W * H);
        send_frame(W * H, 1'b1, 1'b0, 1'b0);
        s_valid = 1'b0;
        wait_drain();
        @(negedge clk);
        check(err0 && err1, "err_set", 64'({err0, err1}), 64'h3);
        push_cols(W * H);
        send_frame(W * H, 1'b0, 1'b0, 1'b0);
        s_valid = 1'b0;
        wait_drain();
        @(negedge clk);
        check(err0, "err_sticky", 64'(err0), 64'd1);

        rst_n = 1'b0;
        #1;
        check(!err0 && !s_ready0 && !m_valid0, "async_reset",
              64'({err0, s_ready0, m_valid0}), 64'd0);
        finish_run();
    end

endmodule

// File: doc/demosaic_g_sched.md
# demosaic_g_sched

Sequencer in front of the green-at-R/B interpolation kernel. It accepts the raw Bayer pixel stream, manages a 4-line ring buffer, and emits one 5-pixel vertical column per accepted pixel, with row-border substitution already applied. Each column carries Bayer-phase and border tags, so the downstream 5x5 window shifter and G kernel can run without any counters of their own.

## Interface
- IMG_W, 1920: active pixels per line (≥8)
- IMG_H, 1080: active lines per frame (≥6)
- DW, 10: pixel width
- BAYER_PAT, 0: 2-bit CFA phase of pixel (0,0); 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  input accept
- s_data  in  DW  raw pixel
- s_sof  in  1  first pixel of frame
- s_eol  in  1  last pixel of line
- m_valid  out  1  column valid
- m_ready  in  1  downstream accept
- m_col  out  5*DW  rows y-2..y+2 at column x, row y-2 in LSBs
- m_is_rb  out  1  center (x,y) is R or B
- m_first  out  1  x==0
- m_last  out  1  x==IMG_W-1
- m_sof  out  1  x==0 and y==0
- err_len  out  1  sticky: s_eol not at x==IMG_W-1, or missing at x==IMG_W-1

## Operation
- States: IDLE, FILL, RUN, FLUSH.
- IDLE: s_ready=1. Beats without s_sof are dropped. A beat with s_sof starts the frame: in_x=0, in_y=0, go to FILL.
- FILL (in_y 0..1): s_ready=1, m_valid=0. Pixels are written to ring slot in_y%4. After the beat at in_x=IMG_W-1 of row 1, go to RUN.
- RUN (in_y 2..IMG_H-1): s_ready=m_ready or !m_valid.
  - Each accepted beat writes slot in_y%4 and reads 4 slots at in_x.
  - The registered output is a column with center y=in_y-2 and x=in_x. The live pixel forms row y+2.
  - After the last pixel of row IMG_H-1, go to FLUSH.
- FLUSH: s_ready=0. Emits 2 full lines of columns (centers IMG_H-2 and IMG_H-1) from stored rows, then goes to IDLE.
- Row substitution (rows outside 0..IMG_H-1):
  - with mirror enabled: row -k → k, row IMG_H-1+k → IMG_H-1-k
  - otherwise: rows clamp to 0 / IMG_H-1
- m_is_rb = ((x^y^pat_x^pat_y)&1)==0, where pat_x=BAYER_PAT[0] and pat_y=BAYER_PAT[1].
- s_sof while not in IDLE aborts the current frame:
  - m_valid drops next cycle; no pending column is emitted.
  - That beat restarts the frame as in_x=0, in_y=0 in FILL.
  - Old ring contents are ignored.
- err_len sets on a mismatched s_eol. Counters follow in_x only (IMG_W wrap); s_eol is not used for wrap. err_len clears only on reset.
- Arithmetic: in_x is ceil(log2 IMG_W) bits, in_y is ceil(log2 IMG_H) bits; both wrap compare at IMG_W-1 / IMG_H-1. Slot index is a 2-bit modular counter.

## Timing
- Reset values: s_ready=0 during reset and 1 on the first cycle after; m_valid=0, m_col=0, m_is_rb=0, m_first=0, m_last=0, m_sof=0, err_len=0. State is IDLE and all counters are 0.
- Latency: input beat accepted at cycle t → column valid at t+1. The line buffer is a 1-cycle synchronous read; address is issued at t on the accept.
- Ring read and write to the same address in the same cycle: the read returns old data (read-before-write).
- m_* holds stable while m_valid=1 and m_ready=0. There are no bubbles in RUN at full throughput; FLUSH emits 1 column per cycle when m_ready=1.
- The FLUSH→IDLE transition occurs on the handshake of the last column. A new s_sof is accepted in the following cycle.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous). Ring contents are don't-care.

## Configuration
- DEMOSAIC_BORDER_MIRROR_EN defined: mirror substitution (row -1→1, -2→2; IMG_H→IMG_H-2, IMG_H+1→IMG_H-3).
- Undefined: edge replication (rows -1, -2 → 0; IMG_H, IMG_H+1 → IMG_H-1).
- Ring depth, latency and handshake are identical in both builds.

## Structure
- Shared package demosaic_pkg:
  - CFA phase encoding constants (PAT_RGGB..PAT_BGGR)
  - state encoding (ST_IDLE, ST_FILL, ST_RUN, ST_FLUSH)
  - DW default
  - the is_rb phase function, also used by the R/B-at-G scheduler
- One sub-module, demosaic_line_ring:
  - 4 x IMG_W x DW simple dual-port RAM with 1 write and 4 parallel read lanes (1 per slot)
  - read-before-write
  - inferable as block RAM

## Test plan
- Ramp frame, IMG_W=8, IMG_H=6, pixel=16*y+x, m_ready=1 → 48 columns. Center (3,2) gives m_col rows = {3,19,35,51,67}. First column at 1 cycle after beat (0,2).
- Border, same frame:
  - mirror build: center (0,0) m_col = {32,16,0,16,32}
  - replicate build: center (0,0) m_col = {0,0,0,16,32}
  - center (0,5) mirror m_col = {48,64,80,64,48}
- BAYER_PAT=0 → m_is_rb=1 at (0,0) and (1,1), 0 at (1,0). BAYER_PAT=1 → m_is_rb=0 at (0,0), 1 at (1,0).
- m_ready toggled 1010… in RUN → s_ready mirrors the stall. m_col is stable while stalled. The 48-column output sequence is identical to the unstalled run.
- s_sof injected at beat (4,3) → m_valid=0 next cycle. The restarted frame produces a correct full 48-column output. err_len stays 0.
- s_eol at x=5 with IMG_W=8 → err_len=1 and stays 1 through the next frame until rst_n=0.
